// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter (mem_arbiter).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner selection. The port that did not win last time
// takes priority when both ports request.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[PORT_DBG]) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU (port 0) and a debug/loader master
// (port 1). Optional grant lock is compiled in with `define MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [1:0]        lock_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output state_t            dbg_state_o
);

  // Handshake: a master raises req_i[p] with we/addr/wdata stable and holds it
  // until ack_o[p] pulses for one cycle; the request fields are captured when
  // granted, and dropping req after capture does not cancel the access.

  state_t              state_q, state_d;
  logic                winner_q, winner_d;
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                arb_valid, arb_winner;
  logic                cap_en, cap_port;

  rr_arb2 u_rr_arb2 (
    .req        (req_i),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

`ifndef MEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      winner_q     <= PORT_CPU;
      last_grant_q <= PORT_DBG;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    ack_o        = 2'b00;
    cap_en       = 1'b0;
    cap_port     = arb_winner;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          cap_en  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = 2'(RD_LAT - 1);
        state_d = (RD_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = RESP;
      end
      RESP: begin
        ack_o        = (winner_q == PORT_DBG) ? 2'b10 : 2'b01;
        last_grant_d = winner_q;
        if (!we_q) rdata_d = ram_data_i;
        state_d      = IDLE;
`ifdef MEM_ARB_LOCK_EN
        // A locked master keeps the RAM: its next request is captured here,
        // skipping IDLE and the round-robin decision.
        if (lock_i[winner_q] && req_i[winner_q]) begin
          cap_en   = 1'b1;
          cap_port = winner_q;
          state_d  = ACCESS;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      winner_d = cap_port;
      we_d     = we_i[cap_port];
      addr_d   = (cap_port == PORT_DBG) ? addr1_i : addr0_i;
      wdata_d  = (cap_port == PORT_DBG) ? wdata1_i : wdata0_i;
    end
  end

  // Read data is forwarded straight from the RAM in the ack cycle, else held.
  assign rdata_o     = (state_q == RESP && !we_q) ? ram_data_i : rdata_q;
  assign ram_we_o    = (state_q == ACCESS) && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT=1 instance plus an
// RD_LAT=3 instance for the latency case).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int SB_W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT (RD_LAT=1) ----------------
  logic [1:0]  req_i, we_i, lock_i, ack_o;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i, rdata_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  state_t      dbg_state;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .lock_i(lock_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .dbg_state_o(dbg_state)
  );

  // ---------------- DUT (RD_LAT=3) ----------------
  logic [1:0]  req3, ack3;
  logic [31:0] addr3, rdata3, ram_addr3, ram_wdata3, ram_rdata3;
  logic        ram_we3;
  state_t      dbg_state3;
  logic [31:0] pipe3 [3];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_i(req3), .we_i(2'b00),
    .addr0_i(addr3), .addr1_i(32'h0), .wdata0_i(32'h0), .wdata1_i(32'h0),
    .ack_o(ack3), .rdata_o(rdata3), .lock_i(2'b00),
    .ram_we_o(ram_we3), .ram_addr_o(ram_addr3), .ram_data_o(ram_wdata3),
    .ram_data_i(ram_rdata3), .dbg_state_o(dbg_state3)
  );

  // ---------------- RAM models ----------------
  logic [31:0] mem [256];
  logic        mem_init_en;

  function automatic logic [31:0] ram_init(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA50000, a};
  endfunction

  always @(posedge clk) begin
    if (mem_init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= ram_init(8'(i));
    end else if (ram_we_o) begin
      mem[ram_addr_o[7:0]] <= ram_data_o;
    end
    ram_data_i <= mem[ram_addr_o[7:0]];
  end

  always @(posedge clk) begin
    pipe3[0] <= {24'hC3C3C3, ram_addr3[7:0]};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign ram_rdata3 = pipe3[2];

  // RAM-side observation of the RD_LAT=1 instance
  int          we_cnt = 0;
  logic [31:0] we_addr, we_data, acc_addr;
  always @(negedge clk) begin
    if (ram_we_o === 1'b1) begin
      we_cnt  = we_cnt + 1;
      we_addr = ram_addr_o;
      we_data = ram_data_o;
    end
    if (dbg_state == ACCESS) acc_addr = ram_addr_o;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [SB_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [7:0] a);
    exp_q.push_back({p, ram_init(a)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    req_i  = 2'b00;
    we_i   = 2'b00;
    lock_i = 2'b00;
    req3   = 2'b00;
    #1;
    check("rst_ack", ack_o, 2'b00);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_ram_we", ram_we_o, 1'b0);
    check("rst_ram_addr", ram_addr_o, 32'h0);
    check("rst_ram_data", ram_data_o, 32'h0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One access on the RD_LAT=1 instance; lat counts the request cycle as 1.
  task automatic single_access(input int p, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, output int lat,
                               output logic [1:0] ak, output logic [31:0] rd);
    @(posedge clk);
    #1;
    req_i[p] = 1'b1;
    we_i[p]  = wr;
    if (p == 0) begin addr0_i = a; wdata0_i = d; end
    else        begin addr1_i = a; wdata1_i = d; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack_o == 2'b00 && lat < 20);
    ak = ack_o;
    rd = rdata_o;
    req_i[p] = 1'b0;
    we_i[p]  = 1'b0;
  endtask

  // Reads from both ports; port 0 walks 0x40.., port 1 walks 0x80...
  task automatic run_traffic(input int n0, input int n1, input logic lk,
                             input int gap, input int budget);
    int rem [2];
    int idx [2];
    int cyc, prev0;
    logic p;
    logic [SB_W-1:0] e;
    rem[0] = n0; rem[1] = n1; idx[0] = 0; idx[1] = 0;
    cyc = 0; prev0 = -1;
    addr0_i = 32'h40;
    addr1_i = 32'h80;
    we_i    = 2'b00;
    req_i   = {n1 > 0, n0 > 0};
    lock_i  = {1'b0, lk};
    while ((rem[0] > 0 || rem[1] > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ack_o != 2'b00) begin
        p = ack_o[1];
        check("tr_ack_onehot", $countones(ack_o), 1);
        check("tr_ack_expected", rem[p] > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tr_grant_data", {p, rdata_o}, e);
        end
        if (p == 1'b0) begin
          if (prev0 >= 0) check("tr_p0_gap", cyc - prev0, gap);
          prev0 = cyc;
        end
        rem[p]--;
        idx[p]++;
        if (rem[p] <= 0) begin
          req_i[p] = 1'b0;
          if (p == 1'b0) lock_i = 2'b00;
        end else if (p == 1'b0) begin
          addr0_i = 32'h40 + idx[0];
        end else begin
          addr1_i = 32'h80 + idx[1];
        end
      end
    end
    check("tr_all_acked", rem[0] + rem[1], 0);
    check("tr_sb_empty", exp_q.size(), 0);
    req_i  = 2'b00;
    lock_i = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, nwait, stray;
    logic [1:0]  ak;
    logic [31:0] rd;
    int          we0;

    reset = 1'b0;
    req_i = 2'b00; we_i = 2'b00; lock_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    req3 = 2'b00; addr3 = '0;
    mem_init_en = 1'b1;
    do_reset();
    mem_init_en = 1'b0;

    // single read, port 0
    single_access(0, 1'b0, 32'h10, 32'h0, lat, ak, rd);
    check("rd_latency", lat, 3);
    check("rd_ack", ak, 2'b01);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_access_addr", acc_addr, 32'h10);
    check("rd_no_write", we_cnt, 0);
    @(negedge clk);
    check("rd_ack_pulse", ack_o, 2'b00);
    check("rd_data_hold", rdata_o, 32'hDEADBEEF);

    // single write, port 1, then read it back from port 0
    we0 = we_cnt;
    single_access(1, 1'b1, 32'h20, 32'h55AA, lat, ak, rd);
    check("wr_latency", lat, 3);
    check("wr_ack", ak, 2'b10);
    check("wr_we_cycles", we_cnt - we0, 1);
    check("wr_addr", we_addr, 32'h20);
    check("wr_data", we_data, 32'h55AA);
    check("wr_rdata_held", rd, 32'hDEADBEEF);
    single_access(0, 1'b0, 32'h20, 32'h0, lat, ak, rd);
    check("wr_readback", rd, 32'h55AA);

    // contention: strict alternation starting with port 0
    do_reset();
    push_exp(1'b0, 8'h40); push_exp(1'b1, 8'h80);
    push_exp(1'b0, 8'h41); push_exp(1'b1, 8'h81);
    run_traffic(2, 2, 1'b0, 6, 60);

    // RD_LAT=3 latency and address stability through WAIT
    @(posedge clk);
    #1;
    req3 = 2'b01;
    addr3 = 32'h50;
    lat = 0; nwait = 0;
    do begin
      @(negedge clk);
      lat++;
      if (dbg_state3 == WAIT) begin
        nwait++;
        check("lat3_addr_stable", ram_addr3, 32'h50);
      end
    end while (ack3 == 2'b00 && lat < 20);
    check("lat3_latency", lat, 5);
    check("lat3_ack", ack3, 2'b01);
    check("lat3_wait_cycles", nwait, 2);
    check("lat3_rdata", rdata3, 32'hC3C3C350);
    req3 = 2'b00;

    // reset asserted during the ACCESS cycle of a write
    @(posedge clk);
    #1;
    req_i[1] = 1'b1; we_i[1] = 1'b1; addr1_i = 32'h30; wdata1_i = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_state_pre", dbg_state, ACCESS);
    check("rstmid_we_pre", ram_we_o, 1'b1);
    #1;
    reset = 1'b1;
    req_i = 2'b00; we_i = 2'b00;
    #1;
    check("rstmid_we", ram_we_o, 1'b0);
    check("rstmid_state", dbg_state, IDLE);
    check("rstmid_ack", ack_o, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_o != 2'b00) stray++;
    end
    check("rstmid_no_ack", stray, 0);
    check("rstmid_no_write", mem[8'h30], ram_init(8'h30));
    single_access(0, 1'b0, 32'h30, 32'h0, lat, ak, rd);
    check("rstmid_after_lat", lat, 3);
    check("rstmid_after_data", rd, ram_init(8'h30));

    // port 0 holds lock for 3 reads while port 1 wants 2
    do_reset();
`ifdef MEM_ARB_LOCK_EN
    push_exp(1'b0, 8'h40); push_exp(1'b0, 8'h41); push_exp(1'b0, 8'h42);
    push_exp(1'b1, 8'h80); push_exp(1'b1, 8'h81);
    run_traffic(3, 2, 1'b1, 2, 100);
`else
    push_exp(1'b0, 8'h40); push_exp(1'b1, 8'h80);
    push_exp(1'b0, 8'h41); push_exp(1'b1, 8'h81);
    push_exp(1'b0, 8'h42);
    run_traffic(3, 2, 1'b1, 6, 100);
`endif

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port system RAM between two requesters:
  - port 0: the CPU control unit's memory interface (fetch and load/store);
  - port 1: a debug/program-loader master.
- Sits between those masters and the RAM pins (we_o, addr_o, data_o, data_i).
- Round-robin arbitration, one outstanding access per requester, fixed-latency req/ack handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles (1..3); the arbiter waits this many cycles before ack.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  2  per-port access request, held high until ack
- we_i  in  2  per-port write enable, valid while req high
- addr0_i  in  ADDR_W  port 0 address
- addr1_i  in  ADDR_W  port 1 address
- wdata0_i  in  DATA_W  port 0 write data
- wdata1_i  in  DATA_W  port 1 write data
- ack_o  out  2  one-cycle completion pulse per port
- rdata_o  out  DATA_W  read data, valid when any ack_o bit is high
- lock_i  in  2  per-port grant lock (only with MEM_ARB_LOCK_EN)
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM read data

Behaviour:
- **Reset values** (asynchronous, take effect immediately): ack_o=0, rdata_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0, state=IDLE, last_grant=1 (so port 0 wins the first contention).
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any req_i bit is set, pick the winner:
    - only one requesting: that port;
    - both requesting: the port != last_grant.
  - Register the winner, its address, write data and write enable.
  - Go to ACCESS.
- **ACCESS (1 cycle):**
  - Drive ram_addr_o, ram_data_o, ram_we_o from the registered values.
  - ram_we_o is high only in this cycle.
  - Load the wait counter with RD_LAT-1.
  - Go to WAIT, or go directly to RESP if RD_LAT=1.
- **WAIT:**
  - Decrement the counter; ram_we_o=0; address held.
  - At 0, go to RESP.
- **RESP (1 cycle):**
  - ack_o[winner]=1.
  - rdata_o=ram_data_i for reads; rdata_o holds its previous value for writes.
  - last_grant=winner; go to IDLE.
- **Latency:** request-to-ack = RD_LAT+2 cycles. Minimum issue interval per arbiter = RD_LAT+2 cycles.
- **Requester obligations:**
  - Keep req and request fields stable until ack.
  - Drop req in the cycle after ack, or keep it high to issue a new access. A held req re-arbitrates in IDLE.
- **Mid-access changes:**
  - Address/data changes after IDLE capture are ignored.
  - A req deassert mid-access does not abort; the ack is still generated.
- **Simultaneous events:**
  - A new request arriving while busy waits; no queueing beyond the req level.
  - Both ports requesting continuously strictly alternate: 0,1,0,1.
- **Reset mid-operation:** the access is abandoned, ram_we_o drops immediately, and no ack is issued.
- **Address width:** addresses pass through unmodified; no wrap or bounds check.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- **Defined:**
  - If lock_i[winner] is high in RESP and req_i[winner] is still high, the FSM goes RESP->ACCESS for the same port. It captures new addr/data/we from that port in RESP, skipping IDLE and round-robin.
  - Locked issue interval = RD_LAT+1.
  - Lock released when lock_i drops; last_grant then updates normally.
- **Undefined:** lock_i is ignored (port may be tied off) and every access passes through IDLE arbitration.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding enum (IDLE, ACCESS, WAIT, RESP);
  - port index constants PORT_CPU=0, PORT_DBG=1.
- One sub-module, rr_arb2: combinational two-way round-robin winner selection from req and last_grant. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- **Single read:** RD_LAT=1, port 0 reads 0x10 with RAM returning 0xDEADBEEF. Expect ram_addr_o=0x10 in the ACCESS cycle, ack_o=2'b01 3 cycles after req, rdata_o=0xDEADBEEF.
- **Single write:** port 1 writes 0x55AA to 0x20. Expect ram_we_o high for exactly 1 cycle with addr 0x20 and data 0x55AA, then ack_o=2'b10; a port-0 read of 0x20 afterwards returns 0x55AA.
- **Contention:** both ports hold req for 4 accesses. Expect grant order 0,1,0,1 and the acks never overlap.
- **Latency:** RD_LAT=3. Expect ack 5 cycles after req and ram_addr_o stable through WAIT.
- **Reset mid-access:** assert reset in the ACCESS cycle of a write. Expect ram_we_o=0 that same cycle, no ack, state IDLE, and a subsequent request served normally.
- **Lock (MEM_ARB_LOCK_EN):** port 0 holds lock with 3 back-to-back reads while port 1 also requests. Expect 3 port-0 acks spaced RD_LAT+1 apart before port 1 is granted; without the macro, strict alternation is expected instead.
